// File: rtl/mu_alu_pkg.sv
// Shared definitions for the Q16.16 mu-ALU and its requester arbiter.
package mu_alu_pkg;

   localparam logic [2:0] OP_ADD       = 3'd0;
   localparam logic [2:0] OP_SUB       = 3'd1;
   localparam logic [2:0] OP_MUL       = 3'd2;
   localparam logic [2:0] OP_DIV       = 3'd3;
   localparam logic [2:0] OP_RSVD4     = 3'd4;
   localparam logic [2:0] OP_INFO_GAIN = 3'd5;

   localparam logic [31:0] Q_ZERO = 32'h0000_0000;
   localparam logic [31:0] ONE    = 32'h0001_0000;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } arb_state_e;

   function automatic logic op_is_legal(input logic [2:0] op);
      return op <= OP_INFO_GAIN;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search starting at a registered pointer; the pointer moves past the
// granted requester whenever the grant is consumed.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_grant_id,
   output logic               o_grant_valid
);

   logic [ID_W-1:0] r_ptr;

   always_comb begin
      int idx;
      o_grant       = '0;
      o_grant_id    = '0;
      o_grant_valid = 1'b0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         idx = (int'(r_ptr) + k) % int'(NUM_REQ);
         if (!o_grant_valid && i_req[idx]) begin
            o_grant_valid = 1'b1;
            o_grant_id    = ID_W'(idx);
            o_grant[idx]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= (o_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/mu_alu_arbiter.sv
// Shares one mu_alu among NUM_REQ requesters: round-robin accept, single-transaction issue,
// bounded completion wait and a backpressured tagged response.
module mu_alu_arbiter
   import mu_alu_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ID_W           = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [3*NUM_REQ-1:0]  req_op,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   output logic [2:0]            alu_op,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic                  alu_valid,
   input  logic [31:0]           alu_result,
   input  logic                  alu_ready,
   input  logic                  alu_overflow,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_result,
   output logic                  rsp_overflow,
   output logic                  rsp_timeout,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_e         r_state, w_state_next;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_grant_id;
   logic               w_grant_valid;
   logic               w_accept;
   logic [2:0]         w_op_sel;
   logic               w_timeout_hit;
   logic               w_drive_alu;

   logic [2:0]         r_op;
   logic [31:0]        r_a, r_b, r_result;
   logic [ID_W-1:0]    r_id;
   logic               r_overflow, r_timeout;
   logic [CNT_W-1:0]   r_cnt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req         (req_valid),
      .i_advance     (w_accept),
      .o_grant       (w_grant),
      .o_grant_id    (w_grant_id),
      .o_grant_valid (w_grant_valid)
   );

   assign w_accept      = (r_state == StIdle) && w_grant_valid;
   assign w_op_sel      = req_op[int'(w_grant_id)*3 +: 3];
   assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !alu_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = op_is_legal(w_op_sel) ? StIssue : StResp;
         StIssue: w_state_next = StWait;
         StWait:  if (alu_ready || w_timeout_hit) w_state_next = StResp;
         StResp:  if (rsp_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_id       <= '0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         if (w_accept) begin
            r_op <= w_op_sel;
            r_a  <= req_a[int'(w_grant_id)*32 +: 32];
            r_b  <= req_b[int'(w_grant_id)*32 +: 32];
            r_id <= w_grant_id;
            // Illegal opcodes skip the ALU and answer immediately with an error.
            if (!op_is_legal(w_op_sel)) begin
               r_result   <= Q_ZERO;
               r_overflow <= 1'b1;
               r_timeout  <= 1'b0;
            end
         end
         if (r_state == StIssue) r_cnt <= '0;
         if (r_state == StWait) begin
            if (alu_ready) begin
               r_result   <= alu_result;
               r_overflow <= alu_overflow;
               r_timeout  <= 1'b0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
               if (w_timeout_hit) begin
                  r_result   <= Q_ZERO;
                  r_overflow <= 1'b1;
                  r_timeout  <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      w_drive_alu  = (r_state != StIdle);
      req_ready    = (r_state == StIdle) ? w_grant : '0;
      alu_valid    = (r_state == StIssue);
      alu_op       = w_drive_alu ? r_op : '0;
      alu_a        = w_drive_alu ? r_a : '0;
      alu_b        = w_drive_alu ? r_b : '0;
      rsp_valid    = (r_state == StResp);
      rsp_id       = rsp_valid ? r_id : '0;
      rsp_result   = rsp_valid ? r_result : '0;
      rsp_overflow = rsp_valid && r_overflow;
      rsp_timeout  = rsp_valid && r_timeout;
      busy         = (r_state != StIdle);
   end

endmodule
